mem_stage_ctrl: RTL

//  Consumer end of the EX/MEM pipeline register: executes the MEM stage for a 16-bit, 8-register

---
 rtl/mem_stage_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives a multi-cycle data memory over a level req/done handshake,
// stalls upstream while an access is in flight and owns the MEM/WB pipeline register.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] readData2In,
    input  logic [15:0] ALUResIn,
    input  logic [15:0] nextPCIn,
    input  logic [2:0]  writeRegIn,
    input  logic        regWriteIn,
    input  logic        memToRegIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    output logic        memEn,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    input  logic [15:0] memRData,
    input  logic        memDone,
    output logic        stall,
    output logic        err,
    output logic [15:0] memDataOut,
    output logic [15:0] ALUResOut,
    output logic [15:0] nextPCOut,
    output logic [2:0]  writeRegOut,
    output logic        regWriteOut,
    output logic        memToRegOut
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           mem_en_q, mem_en_d;
    logic           mem_wr_q, mem_wr_d;
    logic [15:0]    mem_addr_q, mem_addr_d;
    logic [15:0]    mem_wdata_q, mem_wdata_d;

    // Shadow of the accepted EX/MEM entry; the address doubles as the shadow ALU result.
    logic [15:0]    sh_npc_q, sh_npc_d;
    logic [2:0]     sh_wreg_q, sh_wreg_d;
    logic           sh_regw_q, sh_regw_d;
    logic           sh_m2r_q, sh_m2r_d;

    logic [15:0]    wb_rdata_q, wb_rdata_d;
    logic [15:0]    wb_alu_q, wb_alu_d;
    logic [15:0]    wb_npc_q, wb_npc_d;
    logic [2:0]     wb_wreg_q, wb_wreg_d;
    logic           wb_regw_q, wb_regw_d;
    logic           wb_m2r_q, wb_m2r_d;

    logic           acc, ill, timeout, stall_c;

    assign acc     = memReadIn | memWriteIn;
    assign ill     = memReadIn & memWriteIn;
    assign timeout = (state_q == BUSY) && !memDone && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sh_npc_d    = sh_npc_q;
        sh_wreg_d   = sh_wreg_q;
        sh_regw_d   = sh_regw_q;
        sh_m2r_d    = sh_m2r_q;
        wb_rdata_d  = wb_rdata_q;
        wb_alu_d    = wb_alu_q;
        wb_npc_d    = wb_npc_q;
        wb_wreg_d   = wb_wreg_q;
        wb_regw_d   = wb_regw_q;
        wb_m2r_d    = wb_m2r_q;
        stall_c     = 1'b0;

        case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                if (ill) begin
                    // Illegal read+write retires as a bubble so nothing is written back.
                    err_d      = 1'b1;
                    wb_rdata_d = '0;
                    wb_alu_d   = '0;
                    wb_npc_d   = '0;
                    wb_wreg_d  = '0;
                    wb_regw_d  = 1'b0;
                    wb_m2r_d   = 1'b0;
                end else if (acc) begin
                    mem_addr_d  = ALUResIn;
                    mem_wdata_d = readData2In;
                    mem_wr_d    = memWriteIn;
                    sh_npc_d    = nextPCIn;
                    sh_wreg_d   = writeRegIn;
                    sh_regw_d   = regWriteIn;
                    sh_m2r_d    = memToRegIn;
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    state_d     = BUSY;
                    stall_c     = 1'b1;
                end else begin
                    wb_rdata_d = '0;
                    wb_alu_d   = ALUResIn;
                    wb_npc_d   = nextPCIn;
                    wb_wreg_d  = writeRegIn;
                    wb_regw_d  = regWriteIn;
                    wb_m2r_d   = memToRegIn;
                end
            end
            BUSY: begin
                if (memDone) begin
                    // Release the stall on the completion cycle so EX/MEM advances on this edge.
                    wb_rdata_d = mem_wr_q ? 16'h0000 : memRData;
                    wb_alu_d   = mem_addr_q;
                    wb_npc_d   = sh_npc_q;
                    wb_wreg_d  = sh_wreg_q;
                    wb_regw_d  = sh_regw_q;
                    wb_m2r_d   = sh_m2r_q;
                    mem_en_d   = 1'b0;
                    state_d    = IDLE;
                end else if (timeout) begin
                    err_d      = 1'b1;
                    wb_rdata_d = '0;
                    wb_alu_d   = '0;
                    wb_npc_d   = '0;
                    wb_wreg_d  = '0;
                    wb_regw_d  = 1'b0;
                    wb_m2r_d   = 1'b0;
                    mem_en_d   = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    mem_en_d = 1'b1;
                    stall_c  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            sh_npc_q    <= '0;
            sh_wreg_q   <= '0;
            sh_regw_q   <= 1'b0;
            sh_m2r_q    <= 1'b0;
            wb_rdata_q  <= '0;
            wb_alu_q    <= '0;
            wb_npc_q    <= '0;
            wb_wreg_q   <= '0;
            wb_regw_q   <= 1'b0;
            wb_m2r_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sh_npc_q    <= sh_npc_d;
            sh_wreg_q   <= sh_wreg_d;
            sh_regw_q   <= sh_regw_d;
            sh_m2r_q    <= sh_m2r_d;
            wb_rdata_q  <= wb_rdata_d;
            wb_alu_q    <= wb_alu_d;
            wb_npc_q    <= wb_npc_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_regw_q   <= wb_regw_d;
            wb_m2r_q    <= wb_m2r_d;
        end
    end

    assign stall       = stall_c & ~rst;
    assign err         = err_q;
    assign memEn       = mem_en_q;
    assign memWr       = mem_wr_q;
    assign memAddr     = mem_addr_q;
    assign memWData    = mem_wdata_q;
    assign memDataOut  = wb_rdata_q;
    assign ALUResOut   = wb_alu_q;
    assign nextPCOut   = wb_npc_q;
    assign writeRegOut = wb_wreg_q;
    assign regWriteOut = wb_regw_q;
    assign memToRegOut = wb_m2r_q;

endmodule
